mem_stage: RTL and testbench

- Memory-access (ME) stage of the RV32I 5-stage pipeline. Sits directly downstream of the EX_ME register and consumes its register/memory control outputs.
- Performs loads and stores over a valid/ack data bus. Handles byte, half and word sizing, sign/zero extension and fault detection.
- Registers the result into ME/WB outputs for writeback.
- Stalls upstream stages while a bus transaction is outstanding.

---
 rtl/mem_stage_if.sv | 20 ++
 rtl/mem_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_stage.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Valid/ack data bus between the ME stage (master) and data memory (slave).
interface mem_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage: sized loads/stores over a valid/ack bus,
// fault detection, ME/WB result register and upstream stall.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_w,
    input  logic [31:0] reg_data,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic        stall,
    mem_stage_if.master bus,
    output logic        wb_reg_w,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_fault
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         off_q;
    logic [2:0]         funct3_q;
    logic [4:0]         rd_q;
    logic               reg_w_q;

    logic               access;
    logic               is_byte;
    logic               is_half;
    logic               is_word;
    logic               bad_funct3;
    logic               misaligned;
    logic               fault;
    logic               timeout_hit;
    logic [3:0]         st_be;
    logic [31:0]        st_wdata;
    logic [7:0]         byte_lane;
    logic [15:0]        half_lane;
    logic [31:0]        ld_data;

    // Access decode and fault classification on the live EX_ME inputs
    always_comb begin
        access  = mem_r | mem_w;
        is_byte = (funct3[1:0] == 2'b00);
        is_half = (funct3[1:0] == 2'b01);
        is_word = (funct3 == 3'b010);
        case (funct3)
            3'b011, 3'b110, 3'b111: bad_funct3 = 1'b1;
            default:                bad_funct3 = 1'b0;
        endcase
        misaligned = (is_half && mem_addr[0]) || (is_word && (mem_addr[1:0] != 2'b00));
        fault      = access && (bad_funct3 || misaligned || (mem_r && mem_w));
    end

    // Store lane placement; loads always request the full word
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = mem_data;
        if (mem_w) begin
            if (is_byte) begin
                st_be    = 4'b0001 << mem_addr[1:0];
                st_wdata = {4{mem_data[7:0]}};
            end else if (is_half) begin
                st_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{mem_data[15:0]}};
            end
        end
    end

    // Load lane extraction from the latched offset and size
    always_comb begin
        case (off_q)
            2'd0:    byte_lane = bus.bus_rdata[7:0];
            2'd1:    byte_lane = bus.bus_rdata[15:8];
            2'd2:    byte_lane = bus.bus_rdata[23:16];
            default: byte_lane = bus.bus_rdata[31:24];
        endcase
        half_lane = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{byte_lane[7]}}, byte_lane};
            3'b100:  ld_data = {24'd0, byte_lane};
            3'b001:  ld_data = {{16{half_lane[15]}}, half_lane};
            3'b101:  ld_data = {16'd0, half_lane};
            default: ld_data = bus.bus_rdata;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    // Hold upstream while an access is being issued or awaits its ack
    assign stall = (state == IDLE) ? (access && !fault)
                                   : (!bus.bus_ack && !timeout_hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            off_q         <= 2'd0;
            funct3_q      <= 3'd0;
            rd_q          <= 5'd0;
            reg_w_q       <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'd0;
            bus.bus_be    <= 4'd0;
            bus.bus_wdata <= 32'd0;
            wb_reg_w      <= 1'b0;
            wb_rd         <= 5'd0;
            wb_data       <= 32'd0;
            mem_fault     <= 1'b0;
        end else begin
            mem_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (!access) begin
                        wb_reg_w <= reg_w;
                        wb_rd    <= rd;
                        wb_data  <= reg_data;
                    end else if (fault) begin
                        mem_fault <= 1'b1;
                        wb_reg_w  <= 1'b0;
                    end else begin
                        off_q         <= mem_addr[1:0];
                        funct3_q      <= funct3;
                        rd_q          <= rd;
                        reg_w_q       <= reg_w;
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= mem_w;
                        bus.bus_addr  <= {mem_addr[31:2], 2'b00};
                        bus.bus_be    <= st_be;
                        bus.bus_wdata <= st_wdata;
                        wb_reg_w      <= 1'b0;
                        cnt           <= '0;
                        state         <= BUS;
                    end
                end
                BUS: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        wb_rd       <= rd_q;
                        wb_reg_w    <= reg_w_q & !bus.bus_we;
                        if (!bus.bus_we) begin
                            wb_data <= ld_data;
                        end
                        state       <= IDLE;
                    end else if (timeout_hit) begin
                        // Abort: the access is dropped without writeback
                        bus.bus_req <= 1'b0;
                        mem_fault   <= 1'b1;
                        wb_reg_w    <= 1'b0;
                        cnt         <= '0;
                        state       <= IDLE;
                    end else begin
                        wb_reg_w <= 1'b0;
                        cnt      <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: per-instruction behavioural model produces a
// per-cycle expectation queue that one compare process checks on the falling edge.
module tb_mem_stage;

    localparam int unsigned TMO = 4;

    typedef struct packed {
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        wb_w;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_w;
    logic [31:0] reg_data;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        mem_r;
    logic        mem_w;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        stall;
    logic        wb_reg_w;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_fault;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t r;
    exp_t exp_q[$];

    mem_stage_if bus_if ();

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .reg_w    (reg_w),
        .reg_data (reg_data),
        .rd       (rd),
        .funct3   (funct3),
        .mem_r    (mem_r),
        .mem_w    (mem_w),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .stall    (stall),
        .bus      (bus_if.master),
        .wb_reg_w (wb_reg_w),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Reference rules for the stage
    function automatic logic model_fault(input logic mr, input logic mw,
                                         input logic [2:0] f3, input logic [31:0] a);
        int size;
        if (!(mr || mw)) return 1'b0;
        if (mr && mw) return 1'b1;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        size = 1 << f3[1:0];
        return (a % size) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic mw, input logic [2:0] f3,
                                            input logic [1:0] off);
        if (!mw || f3[1:0] == 2'd2) return 4'hF;
        if (f3[1:0] == 2'd0) return 4'b0001 << off;
        return 4'b0011 << off;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] md);
        case (f3[1:0])
            2'd0:    return 32'(md[7:0]) * 32'h0101_0101;
            2'd1:    return 32'(md[15:0]) * 32'h0001_0001;
            default: return md;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdv);
        logic [31:0] sh;
        sh = rdv >> (8 * off);
        case (f3)
            3'd0:    return 32'($signed(sh[7:0]));
            3'd4:    return sh & 32'h0000_00FF;
            3'd1:    return 32'($signed(sh[15:0]));
            3'd5:    return sh & 32'h0000_FFFF;
            default: return rdv;
        endcase
    endfunction

    // One cycle: queue this cycle's expectation, then advance the registered model
    task automatic step(input logic st, input exp_t nx);
        exp_t e;
        e       = r;
        e.stall = st;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        r = nx;
    endtask

    task automatic scramble();
        reg_w    = 1'($urandom);
        rd       = 5'($urandom);
        reg_data = $urandom;
        funct3   = 3'($urandom);
        mem_r    = 1'($urandom);
        mem_w    = 1'($urandom);
        mem_addr = $urandom;
        mem_data = $urandom;
    endtask

    // Execute one EX_ME instruction; d = BUS cycles without ack before the ack
    task automatic exec(input logic rw, input logic [4:0] rdx, input logic [31:0] rdat,
                        input logic [2:0] f3, input logic mr, input logic mw,
                        input logic [31:0] a, input logic [31:0] md,
                        input logic [31:0] rdv, input int d);
        exp_t nx;
        reg_w = rw; rd = rdx; reg_data = rdat; funct3 = f3;
        mem_r = mr; mem_w = mw; mem_addr = a; mem_data = md;
        bus_if.bus_ack   = 1'($urandom);
        bus_if.bus_rdata = $urandom;
        nx       = r;
        nx.fault = 1'b0;
        if (!(mr || mw)) begin
            nx.wb_w = rw; nx.wb_rd = rdx; nx.wb_data = rdat;
            step(1'b0, nx);
        end else if (model_fault(mr, mw, f3, a)) begin
            nx.fault = 1'b1; nx.wb_w = 1'b0;
            step(1'b0, nx);
        end else begin
            nx.req   = 1'b1;
            nx.we    = mw;
            nx.addr  = a & ~32'h3;
            nx.be    = model_be(mw, f3, a[1:0]);
            nx.wdata = model_wdata(f3, md);
            nx.wb_w  = 1'b0;
            step(1'b1, nx);
            for (int k = 0; k < 64; k++) begin
                scramble();
                nx       = r;
                nx.fault = 1'b0;
                if (k == d) begin
                    bus_if.bus_ack   = 1'b1;
                    bus_if.bus_rdata = rdv;
                    nx.req   = 1'b0;
                    nx.wb_w  = rw & mr;
                    nx.wb_rd = rdx;
                    if (mr) nx.wb_data = model_load(f3, a[1:0], rdv);
                    step(1'b0, nx);
                    break;
                end else if (k == int'(TMO) - 1) begin
                    bus_if.bus_ack   = 1'b0;
                    bus_if.bus_rdata = $urandom;
                    nx.req   = 1'b0;
                    nx.fault = 1'b1;
                    nx.wb_w  = 1'b0;
                    step(1'b0, nx);
                    break;
                end else begin
                    bus_if.bus_ack   = 1'b0;
                    bus_if.bus_rdata = $urandom;
                    nx.wb_w = 1'b0;
                    step(1'b1, nx);
                end
            end
        end
        bus_if.bus_ack = 1'b0;
    endtask

    // Single compare process against the expectation queue
    always @(negedge clk) begin
        exp_t e;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("bus_req", 32'(bus_if.bus_req), 32'(e.req));
            chk("mem_fault", 32'(mem_fault), 32'(e.fault));
            chk("wb_reg_w", 32'(wb_reg_w), 32'(e.wb_w));
            if (e.req) begin
                chk("bus_we", 32'(bus_if.bus_we), 32'(e.we));
                chk("bus_addr", bus_if.bus_addr, e.addr);
                chk("bus_be", 32'(bus_if.bus_be), 32'(e.be));
                if (e.we) chk("bus_wdata", bus_if.bus_wdata, e.wdata);
            end
            if (e.wb_w) begin
                chk("wb_rd", 32'(wb_rd), 32'(e.wb_rd));
                chk("wb_data", wb_data, e.wb_data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic        mw;
        exp_t        nx;
        int          kind;

        reset = 1'b1;
        reg_w = 0; rd = 0; reg_data = 0; funct3 = 0;
        mem_r = 0; mem_w = 0; mem_addr = 0; mem_data = 0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
        r = '0;
        #3;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("reset_wb_reg_w", 32'(wb_reg_w), 32'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_mem_fault", 32'(mem_fault), 32'd0);
        @(posedge clk);
        #7 reset = 1'b0;
        @(posedge clk);
        #1;

        // Hand-computed pins on the model itself
        chk("model_lb", model_load(3'd0, 2'd3, 32'h8012_3456), 32'hFFFF_FF80);
        chk("model_lbu", model_load(3'd4, 2'd3, 32'h8012_3456), 32'h0000_0080);
        chk("model_lhu", model_load(3'd5, 2'd2, 32'h8012_3456), 32'h0000_8012);
        chk("model_sb_be", 32'(model_be(1'b1, 3'd0, 2'd3)), 32'h8);
        chk("model_sb_wdata", model_wdata(3'd0, 32'h0000_00A5), 32'hA5A5_A5A5);
        chk("model_lh_fault", 32'(model_fault(1'b1, 1'b0, 3'd1, 32'h101)), 32'd1);

        // Directed scenarios
        exec(1'b1, 5'd5, 32'h10, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0);
        chk("pass_wb_reg_w", 32'(wb_reg_w), 32'd1);
        chk("pass_wb_rd", 32'(wb_rd), 32'd5);
        chk("pass_wb_data", wb_data, 32'h10);
        exec(1'b1, 5'd7, 32'h0, 3'd0, 1'b0, 1'b1, 32'h103, 32'hA5, 32'h0, 0);
        chk("sb_wb_reg_w", 32'(wb_reg_w), 32'd0);
        exec(1'b1, 5'd9, 32'h0, 3'd0, 1'b1, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 0);
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        exec(1'b1, 5'd9, 32'h0, 3'd4, 1'b1, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 1);
        chk("lbu_data", wb_data, 32'h0000_0080);
        exec(1'b1, 5'd9, 32'h0, 3'd5, 1'b1, 1'b0, 32'h102, 32'h0, 32'h8012_3456, 2);
        chk("lhu_data", wb_data, 32'h0000_8012);
        exec(1'b1, 5'd3, 32'h0, 3'd1, 1'b1, 1'b0, 32'h101, 32'h0, 32'h0, 0);
        chk("lh_mis_fault", 32'(mem_fault), 32'd1);
        chk("lh_mis_req", 32'(bus_if.bus_req), 32'd0);
        exec(1'b1, 5'd12, 32'h0, 3'd2, 1'b1, 1'b0, 32'h100, 32'h0, 32'hCAFE_BABE, 3);
        chk("lw_wb_reg_w", 32'(wb_reg_w), 32'd1);
        chk("lw_data", wb_data, 32'hCAFE_BABE);
        exec(1'b1, 5'd12, 32'h0, 3'd2, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0, 99);
        chk("tmo_fault", 32'(mem_fault), 32'd1);
        chk("tmo_req", 32'(bus_if.bus_req), 32'd0);

        // Reset in the middle of a bus transaction
        reg_w = 1; rd = 5'd4; reg_data = 0; funct3 = 3'd2;
        mem_r = 1; mem_w = 0; mem_addr = 32'h200; mem_data = 0;
        nx = r; nx.fault = 0; nx.req = 1; nx.we = 0; nx.addr = 32'h200; nx.be = 4'hF; nx.wb_w = 0;
        step(1'b1, nx);
        nx = r; nx.fault = 0; nx.wb_w = 0;
        step(1'b1, nx);
        #1 reset = 1'b1;
        reg_w = 0; rd = 0; reg_data = 0; funct3 = 0;
        mem_r = 0; mem_w = 0; mem_addr = 0; mem_data = 0;
        #1;
        chk("rst_mid_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_wb_reg_w", 32'(wb_reg_w), 32'd0);
        r = '0;
        @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        exec(1'b1, 5'd5, 32'h10, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0);
        chk("post_rst_wb_reg_w", 32'(wb_reg_w), 32'd1);
        chk("post_rst_wb_data", wb_data, 32'h10);

        // Randomized mix of ALU ops, legal accesses and faulting accesses
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 4) begin
                exec(1'($urandom), 5'($urandom), $urandom, 3'($urandom), 1'b0, 1'b0,
                     $urandom, $urandom, $urandom, 0);
            end else if (kind < 9) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
                mw = 1'($urandom);
                if (mw) f3[2] = 1'b0;
                a = $urandom;
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
                exec(1'($urandom), 5'($urandom), $urandom, f3, !mw, mw,
                     a, $urandom, $urandom, int'($urandom_range(0, 5)));
            end else begin
                exec(1'($urandom), 5'($urandom), $urandom, 3'($urandom), 1'($urandom),
                     1'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 5)));
            end
        end

        exec(1'b0, 5'd0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
